// File: rtl/present_encrypt_sp_layer.sv
// PRESENT-80 encryption round substitution-permutation layer.
// Registers pLayer(sBoxLayer(din)) one clock after in_valid and provides a
// combinational forward S-box for the key-schedule nibble.
// Optional build macro: PRESENT_SP_INV_EN adds the inv input and an inverse
// path invS(invP(din)); without it only the forward tables are built.

// Forward PRESENT S-box as a 16-entry lookup
module present_sbox (
   input  logic [3:0] x_i,
   output logic [3:0] y_o
);
   // Table lookup
   always_comb begin
      y_o = 4'h0;
      case (x_i)
         4'h0: y_o = 4'hC;
         4'h1: y_o = 4'h5;
         4'h2: y_o = 4'h6;
         4'h3: y_o = 4'hB;
         4'h4: y_o = 4'h9;
         4'h5: y_o = 4'h0;
         4'h6: y_o = 4'hA;
         4'h7: y_o = 4'hD;
         4'h8: y_o = 4'h3;
         4'h9: y_o = 4'hE;
         4'hA: y_o = 4'hF;
         4'hB: y_o = 4'h8;
         4'hC: y_o = 4'h4;
         4'hD: y_o = 4'h7;
         4'hE: y_o = 4'h1;
         default: y_o = 4'h2;
      endcase
   end
endmodule

`ifdef PRESENT_SP_INV_EN
// Inverse PRESENT S-box as a 16-entry lookup
module present_inv_sbox (
   input  logic [3:0] x_i,
   output logic [3:0] y_o
);
   // Table lookup
   always_comb begin
      y_o = 4'h0;
      case (x_i)
         4'h0: y_o = 4'h5;
         4'h1: y_o = 4'hE;
         4'h2: y_o = 4'hF;
         4'h3: y_o = 4'h8;
         4'h4: y_o = 4'hC;
         4'h5: y_o = 4'h1;
         4'h6: y_o = 4'h2;
         4'h7: y_o = 4'hD;
         4'h8: y_o = 4'hB;
         4'h9: y_o = 4'h4;
         4'hA: y_o = 4'h6;
         4'hB: y_o = 4'h3;
         4'hC: y_o = 4'h0;
         4'hD: y_o = 4'h7;
         4'hE: y_o = 4'h9;
         default: y_o = 4'hA;
      endcase
   end
endmodule
`endif

module present_encrypt_sp_layer #(
   parameter logic [63:0] RESET_VALUE = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [63:0] din,
   output logic [63:0] dout,
   output logic        out_valid,
   input  logic [3:0]  key_nib_in,
   output logic [3:0]  key_nib_out
`ifdef PRESENT_SP_INV_EN
   ,
   input  logic        inv
`endif
);
   logic [63:0] s_fwd;
   logic [63:0] p_fwd;
   logic [63:0] result;
   logic [63:0] dout_q, dout_d;
   logic        valid_q, valid_d;

   // Sixteen parallel S-boxes followed by the bit permutation (pure wiring)
   for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
      present_sbox u_sbox (.x_i(din[4*gi +: 4]), .y_o(s_fwd[4*gi +: 4]));
   end

   for (genvar gi = 0; gi < 64; gi++) begin : g_play
      localparam int PI = (gi == 63) ? 63 : ((16 * gi) % 63);
      assign p_fwd[PI] = s_fwd[gi];
   end

   // Key-schedule nibble S-box, independent of clock and reset
   present_sbox u_key_sbox (.x_i(key_nib_in), .y_o(key_nib_out));

`ifdef PRESENT_SP_INV_EN
   logic [63:0] p_inv;
   logic [63:0] s_inv;

   // Inverse order: undo the permutation first, then the S-boxes
   for (genvar gi = 0; gi < 64; gi++) begin : g_iplay
      localparam int PI = (gi == 63) ? 63 : ((16 * gi) % 63);
      assign p_inv[gi] = din[PI];
   end

   for (genvar gi = 0; gi < 16; gi++) begin : g_isbox
      present_inv_sbox u_isbox (.x_i(p_inv[4*gi +: 4]), .y_o(s_inv[4*gi +: 4]));
   end

   assign result = inv ? s_inv : p_fwd;
`else
   assign result = p_fwd;
`endif

   // Next state: capture a new result only when din is valid, otherwise hold
   always_comb begin
      dout_d  = dout_q;
      valid_d = 1'b0;
      if (in_valid) begin
         dout_d  = result;
         valid_d = 1'b1;
      end
   end

   // Output register with synchronous reset taking priority over in_valid
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q  <= RESET_VALUE;
         valid_q <= 1'b0;
      end else begin
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   assign dout      = dout_q;
   assign out_valid = valid_q;
endmodule

// File: tb/tb_present_encrypt_sp_layer.sv
// Directed bench for present_encrypt_sp_layer (inverse checks only when
// PRESENT_SP_INV_EN is defined).
module tb_present_encrypt_sp_layer;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [63:0] din;
   logic [63:0] dout;
   logic        out_valid;
   logic [3:0]  key_nib_in;
   logic [3:0]  key_nib_out;
`ifdef PRESENT_SP_INV_EN
   logic        inv = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] sbox_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   present_encrypt_sp_layer #(.RESET_VALUE(64'h0)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .din        (din),
      .dout       (dout),
      .out_valid  (out_valid),
      .key_nib_in (key_nib_in),
      .key_nib_out(key_nib_out)
`ifdef PRESENT_SP_INV_EN
      ,
      .inv        (inv)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   // Advance one rising edge and settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic key_sweep(input string phase);
      for (int k = 0; k < 16; k++) begin
         key_nib_in = 4'(k);
         #1;
         check_val($sformatf("%s key S(%h)", phase, k), {60'h0, key_nib_out}, {60'h0, sbox_tab[k]});
      end
   endtask

   task automatic fwd(input string tag, input logic [63:0] x, input logic [63:0] exp);
      in_valid = 1'b1;
      din      = x;
      step();
      check_val({tag, " dout"}, dout, exp);
      check_val({tag, " valid"}, {63'h0, out_valid}, 64'h1);
   endtask

   initial begin
      logic [63:0] held;
      rst        = 1'b1;
      in_valid   = 1'b1;
      din        = 64'hFFFF_FFFF_FFFF_FFFF;
      key_nib_in = 4'h0;
      #1;
      for (int c = 0; c < 2; c++) begin
         step();
         check_val($sformatf("reset%0d dout", c), dout, 64'h0);
         check_val($sformatf("reset%0d valid", c), {63'h0, out_valid}, 64'h0);
      end
      key_sweep("reset");
      rst = 1'b0;

      fwd("fwd zero",  64'h0000_0000_0000_0000, 64'hFFFF_FFFF_0000_0000);
      fwd("fwd ones",  64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_0000);
      fwd("fwd fives", 64'h5555_5555_5555_5555, 64'h0000_0000_0000_0000);
      fwd("fwd nib0",  64'h0000_0000_0000_0001, 64'hFFFE_FFFF_0000_0001);
      fwd("fwd nib15", 64'hF000_0000_0000_0000, 64'h7FFF_7FFF_8000_0000);

      held     = 64'h7FFF_7FFF_8000_0000;
      in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         din = {$urandom, $urandom};
         step();
         check_val($sformatf("hold%0d dout", c), dout, held);
         check_val($sformatf("hold%0d valid", c), {63'h0, out_valid}, 64'h0);
      end

      key_sweep("run");

`ifdef PRESENT_SP_INV_EN
      inv      = 1'b1;
      in_valid = 1'b1;
      din      = 64'hFFFF_FFFF_0000_0000;
      step();
      check_val("inv dout", dout, 64'h0);
      for (int n = 0; n < 1000; n++) begin
         logic [63:0] x;
         x        = {$urandom, $urandom};
         inv      = 1'b0;
         din      = x;
         step();
         inv      = 1'b1;
         din      = dout;
         step();
         n_checks++;
         if (dout !== x) begin
            n_fail++;
            $display("FAIL roundtrip %0d: got %h expected %h", n, dout, x);
         end
      end
      inv      = 1'b0;
      in_valid = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
